// File: rtl/axilite_gpio_in_irq_if.sv
// AXI-Lite register-bus bundle for the GPIO input/interrupt block.
interface axilite_gpio_in_irq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axilite_gpio_in_irq.sv
// AXI-Lite GPIO input bank: synchronized pin readback, per-pin edge capture
// into W1C status, and a registered level interrupt.
module axilite_gpio_in_irq #(
  parameter int unsigned NUM_GPIO    = 16,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_GPIO-1:0]   gpio_i,
  output logic                  irq_o,
  axilite_gpio_in_irq_if.slave  s_axilite
);
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q;
  logic [NUM_GPIO-1:0] sync, prev_q, evt, w1c_clr;
  logic [NUM_GPIO-1:0] irq_en_q, irq_en_d, edge_sel_q, edge_sel_d, status_q, status_d;
  logic                irq_q, ready_q;
  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, wr_addr;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, wr_data, wr_mask;
  logic [DATA_WIDTH-1:0]   rd_val, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d, wr_strb;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic                aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs;
  logic                do_write, wr_err, rd_err;
  logic                unused_addr_bits;

  function automatic logic [DATA_WIDTH-1:0] zext(input logic [NUM_GPIO-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    r[NUM_GPIO-1:0] = v;
    return r;
  endfunction

  function automatic logic [NUM_GPIO-1:0] merge(input logic [NUM_GPIO-1:0] old,
                                                input logic [DATA_WIDTH-1:0] data,
                                                input logic [DATA_WIDTH-1:0] mask);
    logic [DATA_WIDTH-1:0] t;
    t = (zext(old) & ~mask) | (data & mask);
    return t[NUM_GPIO-1:0];
  endfunction

  assign sync = sync_q[SYNC_STAGES-1];
  assign evt  = (edge_sel_q & sync & ~prev_q) | (~edge_sel_q & ~sync & prev_q);

  // ready_q keeps every ready low while reset is (or has just been) asserted
  assign aw_rdy = ready_q && (w_state_q == W_IDLE) && !aw_done_q;
  assign w_rdy  = ready_q && (w_state_q == W_IDLE) && !w_done_q;
  assign ar_rdy = ready_q && (r_state_q == R_IDLE);
  assign aw_hs  = aw_rdy && s_axilite.awvalid;
  assign w_hs   = w_rdy && s_axilite.wvalid;
  assign ar_hs  = ar_rdy && s_axilite.arvalid;

  assign s_axilite.awready = aw_rdy;
  assign s_axilite.wready  = w_rdy;
  assign s_axilite.arready = ar_rdy;
  assign s_axilite.bvalid  = (w_state_q == W_RESP);
  assign s_axilite.bresp   = bresp_q;
  assign s_axilite.rvalid  = (r_state_q == R_RESP);
  assign s_axilite.rdata   = rdata_q;
  assign s_axilite.rresp   = rresp_q;
  assign irq_o             = irq_q;

  // An address/data beat accepted this cycle is used directly, so the write can
  // complete in the same cycle as the second half of the pair arrives.
  assign wr_addr  = aw_done_q ? awaddr_q : s_axilite.awaddr;
  assign wr_data  = w_done_q ? wdata_q : s_axilite.wdata;
  assign wr_strb  = w_done_q ? wstrb_q : s_axilite.wstrb;
  assign do_write = (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign wr_err   = |wr_addr[ADDR_WIDTH-1:4];
  assign rd_err   = |s_axilite.araddr[ADDR_WIDTH-1:4];
  assign unused_addr_bits = ^{s_axilite.araddr[1:0], wr_addr[1:0]};

  always_comb begin
    wr_mask = '0;
    for (int unsigned k = 0; k < DATA_WIDTH/8; k++) begin
      wr_mask[8*k +: 8] = {8{wr_strb[k]}};
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    w1c_clr    = '0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awaddr_d  = s_axilite.awaddr;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_axilite.wdata;
          wstrb_d  = s_axilite.wstrb;
        end
        if (do_write) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
          if (!wr_err) begin
            unique case (wr_addr[3:2])
              2'd1:    irq_en_d   = merge(irq_en_q, wr_data, wr_mask);
              2'd2:    w1c_clr    = merge('0, wr_data, wr_mask);
              2'd3:    edge_sel_d = merge(edge_sel_q, wr_data, wr_mask);
              default: ;
            endcase
          end
        end
      end
      W_RESP: if (s_axilite.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // A new event on the same cycle as a W1C keeps the bit set
  assign status_d = (status_q & ~w1c_clr) | evt;

  always_comb begin
    unique case (s_axilite.araddr[3:2])
      2'd0:    rd_val = zext(sync);
      2'd1:    rd_val = zext(irq_en_q);
      2'd2:    rd_val = zext(status_q);
      default: rd_val = zext(edge_sel_q);
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_RESP;
        rdata_d   = rd_err ? '0 : rd_val;
        rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      R_RESP: if (s_axilite.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      prev_q     <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_i};
      prev_q     <= sync;
      irq_en_q   <= irq_en_d;
      edge_sel_q <= edge_sel_d;
      status_q   <= status_d;
      irq_q      <= |(status_q & irq_en_q);
      ready_q    <= 1'b1;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end
endmodule

// File: doc/axilite_gpio_in_irq.md
Name: axilite_gpio_in_irq

Overview:
- AXI-Lite responder on the peripheral bus. Samples a bank of external GPIO inputs and exposes their current value through a register.
- Latches per-pin edge events into a write-1-to-clear status register.
- Drives one level interrupt line, which feeds one of the NUM_IRQ system interrupt inputs.
- Completes the GPIO-input side as a register-mapped, interrupt-capable slave of the AXI-Lite crossbar.

Parameters:
- NUM_GPIO, 16, number of input pins (1..32).
- ADDR_WIDTH, 32, AXI-Lite address width; only addr[3:2] are decoded.
- DATA_WIDTH, 32, AXI-Lite data width (fixed at 32).
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer (>=2).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- gpio_i  in  NUM_GPIO  asynchronous external pins
- irq_o  out  1  level interrupt
- s_axilite_awaddr  in  ADDR_WIDTH  write address
- s_axilite_awvalid  in  1  / s_axilite_awready  out  1
- s_axilite_wdata  in  32  / s_axilite_wstrb  in  4
- s_axilite_wvalid  in  1  / s_axilite_wready  out  1
- s_axilite_bresp  out  2  / s_axilite_bvalid  out  1  / s_axilite_bready  in  1
- s_axilite_araddr  in  ADDR_WIDTH  / s_axilite_arvalid  in  1  / s_axilite_arready  out  1
- s_axilite_rdata  out  32  / s_axilite_rresp  out  2  / s_axilite_rvalid  out  1  / s_axilite_rready  in  1

Behaviour:
- Reset:
  - The block has one clock, clk_i. rst_ni is asynchronous and active-low.
  - Reset clears all registers, synchronizer flops and the previous-sample register to 0.
  - Output reset values: all VALIDs 0, awready=wready=arready=0, rdata=0, resp=0, irq_o=0.
- Register map (offset = addr[3:2]*4):
  - 0x0 DATA (RO): synchronized gpio, zero-extended.
  - 0x4 IRQ_EN (RW).
  - 0x8 IRQ_STATUS (W1C).
  - 0xC EDGE_SEL (RW): 1 = rising, 0 = falling.
  - Bits at or above NUM_GPIO read 0 and ignore writes.
- Input path:
  - gpio_i passes through SYNC_STAGES flops to give sync.
  - prev takes sync each cycle.
  - Edge event for bit i: EDGE_SEL[i] ? (sync&~prev) : (~sync&prev).
  - An event sets STATUS[i] on the next edge.
  - Pin-to-STATUS latency is SYNC_STAGES+1 cycles.
- irq_o is registered: irq_o <= |(STATUS & IRQ_EN). It rises one cycle after STATUS.
- Write FSM, states W_IDLE / W_RESP:
  - In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured. AW and W may arrive in either order or in the same cycle.
  - Once both are captured, the write is performed in that cycle and the FSM enters W_RESP with bvalid=1.
  - bvalid holds with bresp stable until bready. Then return to W_IDLE with awready/wready deasserted that cycle (re-asserted the next cycle).
  - No new AW or W is accepted while in W_RESP.
- wstrb: byte lane k updates bits [8k+7:8k] only. For W1C, only bits with strobe set and data 1 are cleared.
- Read FSM, states R_IDLE / R_RESP:
  - arready=1 in R_IDLE.
  - The AR handshake registers rdata and enters R_RESP with rvalid=1 on the next cycle (1-cycle latency).
  - rdata/rresp hold until rready, then return to R_IDLE.
- Address errors: offsets outside 0x0–0xC (addr[ADDR_WIDTH-1:4] != 0) get resp=SLVERR (2'b10), no state change, rdata=0. Writes to DATA are ignored with OKAY.
- Simultaneous events:
  - A new edge event and a W1C on the same STATUS bit in the same cycle: set wins, bit remains 1.
  - A read and a write in the same cycle are independent. A read of STATUS in the W1C cycle returns the pre-clear value.
- EDGE_SEL change: prev is not reset, so a change may produce at most one event per bit, evaluated with the new polarity from the next cycle.
- Reset mid-transaction: outstanding responses are dropped; the master must not expect bvalid/rvalid after reset.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC with gpio_i=16'h00A5 -> DATA=32'h000000A5, others 0, OKAY, rvalid exactly 1 cycle after AR handshake.
- Write IRQ_EN=32'h1, EDGE_SEL=32'h1, toggle gpio_i[0] 0→1 -> STATUS=1 after 3 cycles, irq_o=1 the cycle after; write 0x8=32'h1 -> STATUS=0, irq_o=0 next cycle.
- Present W two cycles before AW, holding bready=0 for 5 cycles -> bvalid held, awready/wready low during W_RESP, single register update.
- Write 0x8=32'h1 in the same cycle as a new rising event on bit 0 -> STATUS[0] stays 1.
- Access offset 0x10 for read and write -> SLVERR (2'b10), rdata=0, no register change. Write 0x4 with wstrb=4'b0010, data=32'hFFFF -> IRQ_EN=32'h0000FF00.
- Falling mode (EDGE_SEL=0), pulse gpio_i[3] 1→0→1 -> only STATUS[3] set once; assert rst_ni low mid-read -> rvalid=0, irq_o=0 immediately.
